// File: rtl/lr_stack_pkg.sv
// Shared defaults and the clog2 helper for the return-address stack and the
// jump unit.
package lr_stack_pkg;

  localparam int LR_WIDTH = 8;
  localparam int LR_DEPTH = 8;

  // Ceiling log2, usable in constant expressions; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage : lr_stack_pkg

// File: rtl/lr_mem.sv
// DEPTH x WIDTH register file for the return-address stack: one synchronous
// write port, one asynchronous read port, no reset on storage.
module lr_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : lr_mem

// File: rtl/lr_stack.sv
// Link-register stack: calls push pc_in+1, returns pop; call+ret together
// replaces the top entry. Overflow/underflow are sticky until err_clr.
module lr_stack
  import lr_stack_pkg::*;
#(
  parameter int WIDTH = LR_WIDTH,
  parameter int DEPTH = LR_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         pc_in,
  input  logic                     call,
  input  logic                     ret,
  input  logic                     err_clr,
  output logic [WIDTH-1:0]         lr_addr,
  output logic [clog2(DEPTH):0]    depth,
  output logic                     empty,
  output logic                     full,
  output logic                     ovf,
  output logic                     unf
);

  localparam int PW = clog2(DEPTH);
  localparam int DW = PW + 1;

  logic [DW-1:0]    depth_q, depth_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             is_empty, is_full;
  logic             do_push, do_pop, do_replace;
  logic             ovf_set, unf_set;
  logic [WIDTH-1:0] push_val;
  logic [DW-1:0]    top_idx;
  logic             mem_we;
  logic [PW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_rdata;

  assign is_empty = (depth_q == '0);
  assign is_full  = (depth_q == DW'(DEPTH));
  assign push_val = pc_in + WIDTH'(1);
  assign top_idx  = depth_q - DW'(1);

  // Call+ret on an empty stack has nothing to return from, so it is a plain push.
  assign do_replace = call && ret && !is_empty;
  assign do_push    = call && (!ret ? !is_full : is_empty);
  assign do_pop     = ret && !call && !is_empty;
  assign ovf_set    = call && !ret && is_full;
  assign unf_set    = ret && !call && is_empty;

  always_comb begin
    depth_d   = depth_q;
    mem_we    = 1'b0;
    mem_waddr = depth_q[PW-1:0];
    if (do_push) begin
      depth_d = depth_q + DW'(1);
      mem_we  = 1'b1;
    end else if (do_replace) begin
      mem_we    = 1'b1;
      mem_waddr = top_idx[PW-1:0];
    end else if (do_pop) begin
      depth_d = top_idx;
    end
  end

  // A new error event wins over a clear issued in the same cycle.
  assign ovf_d = ovf_set || (ovf_q && !err_clr);
  assign unf_d = unf_set || (unf_q && !err_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  lr_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (push_val),
    .raddr_i (top_idx[PW-1:0]),
    .rdata_o (mem_rdata)
  );

  assign lr_addr = is_empty ? '0 : mem_rdata;
  assign depth   = depth_q;
  assign empty   = is_empty;
  assign full    = is_full;
  assign ovf     = ovf_q;
  assign unf     = unf_q;

endmodule : lr_stack
